// File: rtl/fft_frame_seq.sv
// ---------------------------------------------------------------------------
// fft_frame_seq
//  Frame sequencer for a streaming FFT core. Offers FFT_LEN samples to the
//  core sink port (valid/sop/eop with ready backpressure), then follows the
//  core source port, numbering each output beat with a bin index so that
//  harmonic-capture logic can pick bins. Each unloaded frame ends with a
//  one-cycle frame_done or len_err pulse. Single-shot or continuous with a
//  programmable idle gap between frames.
//
// Ports
//  sys_clk, sys_rst_n     clock, synchronous active-low reset
//  start, cont_mode       frame request / auto-restart after GAP
//  abort                  return to IDLE next cycle, no done/err pulse
//  sink_ready             core can accept a sample
//  sink_valid/sop/eop     sample offer to core (driven from registers only)
//  sample_take            sample accepted this cycle (ADC path advances)
//  source_valid/sop/eop   core output stream
//  bin_idx, bin_vld       index of the current output beat, qualifier
//  frame_done, len_err    one-cycle result pulses (registered)
//  busy                   sequencer not idle
// ---------------------------------------------------------------------------
module fft_frame_seq #(
    parameter int FFT_LEN = 1024,
    parameter int CNT_W   = 10,
    parameter int GAP_CYC = 16,
    parameter int TMO_CYC = 8192
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             abort,
    input  logic             sink_ready,
    output logic             sink_valid,
    output logic             sink_sop,
    output logic             sink_eop,
    output logic             sample_take,
    input  logic             source_valid,
    input  logic             source_sop,
    input  logic             source_eop,
    output logic [CNT_W-1:0] bin_idx,
    output logic             bin_vld,
    output logic             frame_done,
    output logic             len_err,
    output logic             busy
);

    localparam int TMO_W = $clog2(TMO_CYC);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] WAIT_OUT = 3'd2;
    localparam logic [2:0] UNLOAD   = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FFT_LEN - 1);
    // The timeout fires on the edge where tmo would reach TMO_CYC-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] scnt_reg, scnt_next;
    logic [CNT_W-1:0] bin_reg, bin_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    always_comb begin
        state_next = state_reg;
        scnt_next  = scnt_reg;
        bin_next   = bin_reg;
        tmo_next   = tmo_reg;
        gap_next   = gap_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        if (abort) begin
            state_next = IDLE;
            scnt_next  = '0;
            bin_next   = '0;
            tmo_next   = '0;
            gap_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = LOAD;
                        scnt_next  = '0;
                    end
                end
                LOAD: begin
                    if (sink_ready) begin
                        if (scnt_reg == CNT_LAST) begin
                            state_next = WAIT_OUT;
                            scnt_next  = '0;
                            tmo_next   = '0;
                        end else begin
                            scnt_next = scnt_reg + 1'b1;
                        end
                    end
                end
                WAIT_OUT: begin
                    if (source_valid && source_sop) begin
                        // The sop beat itself is bin 0; the next beat is bin 1.
                        state_next = UNLOAD;
                        bin_next   = CNT_W'(1);
                        tmo_next   = '0;
                    end else if (tmo_reg == TMO_LAST) begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                        tmo_next   = '0;
                    end else begin
                        tmo_next = tmo_reg + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (source_valid) begin
                        if (source_eop) begin
                            if ((bin_reg == CNT_LAST) && !source_sop) begin
                                done_next = 1'b1;
                            end else begin
                                err_next = 1'b1;
                            end
                            state_next = cont_mode ? GAP : IDLE;
                            bin_next   = '0;
                            gap_next   = '0;
                        end else if (source_sop) begin
                            // Unexpected restart: this beat becomes bin 0.
                            err_next = 1'b1;
                            bin_next = CNT_W'(1);
                        end else begin
                            bin_next = bin_reg + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        state_next = cont_mode ? LOAD : IDLE;
                        scnt_next  = '0;
                        gap_next   = '0;
                    end else begin
                        gap_next = gap_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
            scnt_reg  <= '0;
            bin_reg   <= '0;
            tmo_reg   <= '0;
            gap_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            scnt_reg  <= scnt_next;
            bin_reg   <= bin_next;
            tmo_reg   <= tmo_next;
            gap_reg   <= gap_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Sink outputs depend on registered state only, never on sink_ready.
    assign sink_valid  = (state_reg == LOAD);
    assign sink_sop    = (state_reg == LOAD) && (scnt_reg == '0);
    assign sink_eop    = (state_reg == LOAD) && (scnt_reg == CNT_LAST);
    assign sample_take = sink_valid && sink_ready;

    assign bin_vld = ((state_reg == UNLOAD) && source_valid) ||
                     ((state_reg == WAIT_OUT) && source_valid && source_sop);
    assign bin_idx = ((state_reg == UNLOAD) && source_valid && source_sop) ? '0 : bin_reg;

    assign frame_done = done_reg;
    assign len_err    = err_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fft_frame_seq.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_seq
//  Directed bench for fft_frame_seq with FFT_LEN=16, GAP_CYC=4, TMO_CYC=64.
//  Inputs are driven just after the falling edge and outputs are sampled
//  1 ns later, well away from the rising edge. The bench plays the FFT core
//  on the source side with a fixed 3-cycle latency.
// ---------------------------------------------------------------------------
module tb_fft_frame_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       start, cont_mode, abort, sink_ready;
    logic       sink_valid, sink_sop, sink_eop, sample_take;
    logic       source_valid, source_sop, source_eop;
    logic [3:0] bin_idx;
    logic       bin_vld, frame_done, len_err, busy;

    int checks = 0;
    int passed = 0;

    always #5 sys_clk = ~sys_clk;

    fft_frame_seq #(.FFT_LEN(16), .CNT_W(4), .GAP_CYC(4), .TMO_CYC(64)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .start(start), .cont_mode(cont_mode), .abort(abort),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sample_take(sample_take),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .bin_idx(bin_idx), .bin_vld(bin_vld), .frame_done(frame_done),
        .len_err(len_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Pulse start in IDLE; returns in the first LOAD cycle.
    task automatic do_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        #1;
    endtask

    // Feed one frame; stall sink_ready for stall_len cycles once stall_at
    // samples have been taken. Returns in the cycle of the accepted eop.
    task automatic load_frame(input int stall_at, input int stall_len,
                              output int takes, output int bad);
        int stall;
        takes = 0;
        bad   = 0;
        stall = 0;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge sys_clk);
            if (takes == stall_at && stall < stall_len) begin
                sink_ready = 1'b0;
                stall++;
            end else begin
                sink_ready = 1'b1;
            end
            #1;
            if (!sink_ready) begin
                if (sink_valid !== 1'b1 || sink_eop !== 1'b0 ||
                    dut.scnt_reg !== 4'(stall_at)) bad++;
            end
            if (sample_take === 1'b1) begin
                if (sink_sop !== (takes == 0)) bad++;
                if (sink_eop !== (takes == 15)) bad++;
                takes++;
                if (sink_eop === 1'b1) break;
            end
        end
        sink_ready = 1'b1;
    endtask

    // Core model: 3 idle cycles, then beats 0..eop_at with sop on beat 0.
    // Returns in the cycle after the last beat with the pulse outputs sampled.
    task automatic unload(input int eop_at, output int bin_bad,
                          output logic done_o, output logic err_o);
        bin_bad = 0;
        repeat (3) @(negedge sys_clk);
        for (int b = 0; b <= eop_at; b++) begin
            @(negedge sys_clk);
            source_valid = 1'b1;
            source_sop   = (b == 0);
            source_eop   = (b == eop_at);
            #1;
            if (bin_vld !== 1'b1 || bin_idx !== 4'(b)) bin_bad++;
        end
        @(negedge sys_clk);
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        #1;
        done_o = frame_done;
        err_o  = len_err;
    endtask

    initial begin
        int   takes, bad, bin_bad, early, idle_bad;
        logic done_o, err_o;

        sys_rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; abort = 1'b0;
        sink_ready = 1'b1; source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        #1;
        chk("rst_sink_valid", sink_valid, 1'b0);
        chk("rst_sop_eop", {sink_sop, sink_eop, sample_take}, 3'b000);
        chk("rst_bin", {bin_vld, bin_idx}, 5'd0);
        chk("rst_pulses", {frame_done, len_err, busy}, 3'b000);
        sys_rst_n = 1'b1;

        // 1: plain single-shot frame
        do_start();
        chk("t1_start_latency", {sink_valid, sink_sop, busy}, 3'b111);
        load_frame(-1, 0, takes, bad);
        chk("t1_takes", takes, 16);
        chk("t1_sop_eop", bad, 0);
        unload(15, bin_bad, done_o, err_o);
        chk("t1_bins", bin_bad, 0);
        chk("t1_done", {done_o, err_o}, 2'b10);
        chk("t1_busy_fall", busy, 1'b0);
        @(negedge sys_clk); #1;
        chk("t1_done_one_cycle", frame_done, 1'b0);

        // 2: backpressure at scnt=5 for 3 cycles
        do_start();
        load_frame(5, 3, takes, bad);
        chk("t2_takes", takes, 16);
        chk("t2_stall_hold", bad, 0);
        unload(15, bin_bad, done_o, err_o);
        chk("t2_done", {done_o, err_o, bin_bad[0]}, 3'b100);

        // 3: continuous mode, three frames
        cont_mode = 1'b1;
        do_start();
        for (int f = 0; f < 3; f++) begin
            load_frame(-1, 0, takes, bad);
            chk("t3_takes", takes, 16);
            if (f == 2) cont_mode = 1'b0;
            unload(15, bin_bad, done_o, err_o);
            chk("t3_done", {done_o, err_o, bin_bad[0]}, 3'b100);
            if (f < 2) begin
                idle_bad = 0;
                if (sink_valid !== 1'b0) idle_bad++;
                for (int k = 1; k < 4; k++) begin
                    @(negedge sys_clk); #1;
                    if (sink_valid !== 1'b0) idle_bad++;
                end
                @(negedge sys_clk); #1;
                chk("t3_gap_idle", idle_bad, 0);
                chk("t3_gap_restart_sop", {sink_valid, sink_sop}, 2'b11);
            end else begin
                chk("t3_last_busy", busy, 1'b0);
            end
        end

        // 4a: source_eop at bin 11
        do_start();
        load_frame(-1, 0, takes, bad);
        unload(11, bin_bad, done_o, err_o);
        chk("t4_short_frame", {done_o, err_o, bin_bad[0]}, 3'b010);

        // 4b: no source_sop at all -> timeout 64 cycles after accepted eop
        do_start();
        load_frame(-1, 0, takes, bad);
        early = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge sys_clk); #1;
            if (k < 64 && (len_err !== 1'b0 || busy !== 1'b1)) early++;
        end
        chk("t4_tmo_early", early, 0);
        chk("t4_tmo_err", {len_err, frame_done, busy}, 3'b100);

        // 5: abort at scnt=7
        do_start();
        repeat (7) @(negedge sys_clk);
        abort = 1'b1;
        #1;
        chk("t5_abort_take", {sample_take, dut.scnt_reg}, {1'b1, 4'd7});
        @(negedge sys_clk);
        abort = 1'b0;
        #1;
        chk("t5_abort_idle", {sink_valid, busy, len_err, frame_done}, 4'b0000);
        do_start();
        chk("t5_restart_sop", {sink_valid, sink_sop}, 2'b11);
        load_frame(-1, 0, takes, bad);
        chk("t5_takes", takes, 16);

        // 6: reset mid-UNLOAD, with start held during reset
        repeat (3) @(negedge sys_clk);
        for (int b = 0; b < 6; b++) begin
            @(negedge sys_clk);
            source_valid = 1'b1;
            source_sop   = (b == 0);
        end
        @(negedge sys_clk);
        source_sop = 1'b0;
        sys_rst_n  = 1'b0;
        start      = 1'b1;
        #1;
        chk("t6_in_unload", {busy, bin_vld, bin_idx}, {1'b1, 1'b1, 4'd6});
        @(negedge sys_clk);
        sys_rst_n    = 1'b1;
        start        = 1'b0;
        source_valid = 1'b0;
        #1;
        chk("t6_after_rst", {sink_valid, sink_sop, sink_eop, sample_take, bin_vld,
                             bin_idx, frame_done, len_err, busy}, 12'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
